// File: rtl/seg_scan_decoder_if.sv
// Scanned 7-segment display bus plus decoded frame outputs.
// master drives the display scan, slave is the decoder.
interface seg_scan_decoder_if;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        seg_valid;
  logic [15:0] digits;
  logic        frame_valid;
  logic [3:0]  err_mask;
  logic        timeout;

  modport master (
    output seg,
    output an,
    output seg_valid,
    input  digits,
    input  frame_valid,
    input  err_mask,
    input  timeout
  );

  modport slave (
    input  seg,
    input  an,
    input  seg_valid,
    output digits,
    output frame_valid,
    output err_mask,
    output timeout
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers 4-digit BCD frames from a multiplexed 7-segment scan,
// debouncing each slot and dropping frames that stall too long.
module seg_scan_decoder #(
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam logic [3:0]  SC = 4'(STABLE_CNT);
  localparam logic [15:0] TO = 16'(TIMEOUT);

  state_t      state;
  logic [10:0] prev_key;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [15:0] tcnt;
  logic [15:0] tcnt_inc;
  logic [15:0] work;
  logic [15:0] work_nxt;
  logic [3:0]  werr;
  logic [3:0]  werr_nxt;
  logic [3:0]  seen;
  logic [3:0]  seen_nxt;
  logic [15:0] digits_q;
  logic [3:0]  err_q;
  logic        fv_q;
  logic        to_q;

  logic [6:0]  pat;
  logic [3:0]  sel;
  logic [10:0] key;
  logic [1:0]  slot;
  logic [3:0]  slot_bit;
  logic        valid;
  logic        match;
  logic        acc;
  logic [3:0]  dec;
  logic        bad;
  logic        unused_dp;

  assign pat       = bus.seg[7:1];
  assign sel       = ~bus.an;
  assign key       = {bus.an, pat};
  assign unused_dp = bus.seg[0];

  // Only a single selected digit makes a usable sample.
  always_comb begin
    slot     = 2'd0;
    slot_bit = 4'b0000;
    valid    = 1'b0;
    unique case (sel)
      4'b0001: begin
        slot     = 2'd0;
        slot_bit = 4'b0001;
        valid    = bus.seg_valid;
      end
      4'b0010: begin
        slot     = 2'd1;
        slot_bit = 4'b0010;
        valid    = bus.seg_valid;
      end
      4'b0100: begin
        slot     = 2'd2;
        slot_bit = 4'b0100;
        valid    = bus.seg_valid;
      end
      4'b1000: begin
        slot     = 2'd3;
        slot_bit = 4'b1000;
        valid    = bus.seg_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    dec = 4'hF;
    bad = 1'b1;
    unique case (pat)
      7'b0000001: begin dec = 4'd0; bad = 1'b0; end
      7'b1001111: begin dec = 4'd1; bad = 1'b0; end
      7'b0010010: begin dec = 4'd2; bad = 1'b0; end
      7'b0000110: begin dec = 4'd3; bad = 1'b0; end
      7'b1001100: begin dec = 4'd4; bad = 1'b0; end
      7'b0100100: begin dec = 4'd5; bad = 1'b0; end
      7'b0100000: begin dec = 4'd6; bad = 1'b0; end
      7'b0001111: begin dec = 4'd7; bad = 1'b0; end
      7'b0000000: begin dec = 4'd8; bad = 1'b0; end
      7'b0000100: begin dec = 4'd9; bad = 1'b0; end
      default: ;
    endcase
  end

  assign match = (key == prev_key);

  always_comb begin
    if (!match)
      cnt_nxt = 4'd1;
    else if (cnt == SC)
      cnt_nxt = SC;
    else
      cnt_nxt = cnt + 4'd1;
  end

  // A saturated counter on an unchanged pattern must not re-accept.
  assign acc = valid && (cnt_nxt == SC) &&
               !(match && (cnt == SC));

  always_comb begin
    work_nxt = work;
    werr_nxt = werr;
    work_nxt[{slot, 2'b00} +: 4] = dec;
    werr_nxt[slot]               = bad;
  end

  assign seen_nxt = seen | slot_bit;
  assign tcnt_inc = tcnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prev_key <= '0;
      cnt      <= '0;
      tcnt     <= '0;
      work     <= '0;
      werr     <= '0;
      seen     <= '0;
      digits_q <= '0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      to_q <= 1'b0;
      if (valid) begin
        prev_key <= key;
        cnt      <= cnt_nxt;
      end else begin
        cnt <= '0;
      end
      if (acc) begin
        work <= work_nxt;
        werr <= werr_nxt;
      end
      unique case (state)
        CAPTURE: begin
          if (acc) begin
            tcnt <= '0;
            if (seen_nxt == 4'hF) begin
              state    <= EMIT;
              seen     <= '0;
              digits_q <= work_nxt;
              err_q    <= werr_nxt;
              fv_q     <= 1'b1;
            end else begin
              seen <= seen_nxt;
            end
          end else if (tcnt_inc == TO) begin
            state <= IDLE;
            seen  <= '0;
            tcnt  <= '0;
            to_q  <= 1'b1;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        // IDLE and EMIT: an acceptance here opens a new frame.
        default: begin
          tcnt <= '0;
          if (acc) begin
            state <= CAPTURE;
            seen  <= slot_bit;
          end else begin
            state <= IDLE;
            seen  <= '0;
          end
        end
      endcase
    end
  end

  assign bus.digits      = digits_q;
  assign bus.err_mask    = err_q;
  assign bus.frame_valid = fv_q;
  assign bus.timeout     = to_q;

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CNT, default 4: consecutive identical valid samples needed before a digit is accepted (range 1..15).
REQ-002 Parameter TIMEOUT, default 1000: clock cycles allowed between accepted digits within one frame (range 2..65535).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 seg  input  8  active-low segment bus; bit7..bit1 = a,b,c,d,e,f,g; bit0 = dp, ignored.
REQ-006 an  input  4  active-low digit select; an[i]=0 selects slot i.
REQ-007 seg_valid  input  1  sample strobe; seg and an are sampled only when high.
REQ-008 digits  output  16  last completed frame; slot i in digits[4i+3:4i], BCD 0..9 or 4'hF for an unrecognised pattern.
REQ-009 frame_valid  output  1  one-cycle pulse when digits/err_mask update.
REQ-010 err_mask  output  4  bit i set when slot i of the last frame held an unrecognised pattern.
REQ-011 timeout  output  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-012 Decode table on seg[7:1] SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; any other value decodes to 4'hF with error.
REQ-013 A sample is valid only when seg_valid=1 and exactly one an bit is 0; invalid samples SHALL clear the stability counter.
REQ-014 Stability counter SHALL increment on each valid sample whose {an, seg[7:1]} equals the previous valid sample, reload to 1 on a differing one, and saturate at STABLE_CNT.
REQ-015 On the cycle the counter reaches STABLE_CNT, the decoded value SHALL be written to the selected slot's working register and its seen bit set; no re-acceptance until the pattern changes.
REQ-016 Re-acceptance of an already-seen slot within a frame SHALL overwrite its value and error bit (latest wins).
REQ-017 FSM states IDLE, CAPTURE, EMIT; IDLE->CAPTURE on first acceptance; CAPTURE->EMIT when all four seen bits are set; EMIT->IDLE after one cycle.
REQ-018 In EMIT, digits and err_mask SHALL load from the working registers and frame_valid SHALL be 1; latency is exactly 1 cycle after the fourth acceptance.
REQ-019 In EMIT, seen bits and timeout counter SHALL clear; an acceptance in the EMIT cycle SHALL count toward the next frame.
REQ-020 Timeout counter SHALL reset on every acceptance and increment each CAPTURE cycle; on reaching TIMEOUT, timeout SHALL pulse 1 cycle, seen bits clear, state->IDLE; digits and err_mask SHALL hold.
REQ-021 If the completing acceptance and timeout expiry coincide, the acceptance SHALL win (EMIT, no timeout pulse).
REQ-022 digits and err_mask SHALL hold between frames.

Reset
REQ-023 While rst=1: state IDLE, digits=16'h0000, err_mask=4'h0, frame_valid=0, timeout=0, seen bits, stability and timeout counters cleared.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame with no frame_valid or timeout pulse.

Verification
REQ-025 Scan slots 0..3 with patterns for 1,2,3,4, each held 4 valid samples -> frame_valid pulses 1 cycle after slot 3's 4th sample, digits=16'h4321, err_mask=0.
REQ-026 Slot 2 driven with seg=8'hFE (all off) for 4 samples, others valid 0 -> digits[11:8]=4'hF, err_mask=4'b0100.
REQ-027 Slot 1 pattern held only 3 samples then changes, an=4'b1100 samples interleaved -> no acceptance for slot 1, no frame_valid.
REQ-028 Accept slots 0 and 1, then idle for TIMEOUT cycles -> timeout pulse 1 cycle, digits unchanged, next full scan produces a correct frame.
REQ-029 Accept slot 0 as 5 then 7 before slots 1..3 -> frame reports slot 0 = 7.
REQ-030 Assert rst after three slots accepted, then complete slot 3 only -> no frame_valid; digits=16'h0000.
